// File: rtl/hog_lite_ctrl.sv
// hog_lite_ctrl
//   Register/control slave on the Xillybus-Lite user port for the HOG/SVM
//   detection core. Holds core configuration, issues start commands through
//   an IDLE/RUN state machine, buffers detection scores in a result FIFO that
//   the host drains through the RESULT register, and pulses user_irq on frame
//   completion.
//   Optional feature macro: HOG_LITE_CYCLE_CNT_EN (RUN-cycle counter at 0x18).
//
//   Result handshake (core -> FIFO): a word is transferred on a rising clock
//   edge where res_valid is high and the FIFO accepts it. res_ready is !full.
//   While full, a word offered in the same cycle as a RESULT pop is still
//   taken because the pop frees its slot on that edge; any other word offered
//   while res_ready is low is dropped and flags OVF.
//
//   dbg_state mirrors the FSM state (0 = IDLE, 1 = RUN) for checkers.
module hog_lite_ctrl #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] ID_VALUE   = 32'h484F4731
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic        user_wren,
  input  logic [3:0]  user_wstrb,
  input  logic        user_rden,
  input  logic [31:0] user_addr,
  input  logic [31:0] user_wr_data,
  output logic [31:0] user_rd_data,
  output logic        user_irq,
  output logic        core_start,
  output logic [31:0] core_win_cfg,
  output logic [31:0] core_thresh,
  input  logic        core_done,
  input  logic        res_valid,
  input  logic [31:0] res_data,
  output logic        res_ready,
  output logic        dbg_state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Register offsets, word index user_addr[4:2]
  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_WIN    = 3'd2;
  localparam logic [2:0] A_THRESH = 3'd3;
  localparam logic [2:0] A_RESULT = 3'd4;
  localparam logic [2:0] A_ID     = 3'd5;
  localparam logic [2:0] A_CYCLES = 3'd6;

  state_t state_q, state_d;
  logic   start_fire;
  logic   done_hit;

  logic [2:0]  reg_idx;
  logic        wr_ctrl, wr_status, wr_win, wr_thresh;
  logic        rd_result;
  logic        start_cmd, soft_rst_cmd;
  logic        irq_en_q, done_q, ovf_q;
  logic [31:0] rd_mux;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [31:0]   count_ext;
  logic          fifo_empty, fifo_full;
  logic          push, pop, ovf_set;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{user_addr[31:5], user_addr[1:0]};

  // Access decode
  assign reg_idx   = user_addr[4:2];
  assign wr_ctrl   = user_wren & (reg_idx == A_CTRL) & user_wstrb[0];
  assign wr_status = user_wren & (reg_idx == A_STATUS) & user_wstrb[0];
  assign wr_win    = user_wren & (reg_idx == A_WIN);
  assign wr_thresh = user_wren & (reg_idx == A_THRESH);
  assign rd_result = user_rden & (reg_idx == A_RESULT);

  // SOFT_RST dominates START when both bits are written together
  assign soft_rst_cmd = wr_ctrl & user_wr_data[1];
  assign start_cmd    = wr_ctrl & user_wr_data[0] & ~user_wr_data[1];

  // FSM state register
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state; START in RUN and core_done in IDLE fall through unused
  always_comb begin
    state_d    = state_q;
    start_fire = 1'b0;
    done_hit   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_cmd) begin
          state_d    = S_RUN;
          start_fire = 1'b1;
        end
      end
      S_RUN: begin
        if (soft_rst_cmd) begin
          state_d = S_IDLE;
        end else if (core_done) begin
          state_d  = S_IDLE;
          done_hit = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dbg_state = state_q;

  // Start pulse and interrupt pulse, both one cycle after their cause
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      core_start <= 1'b0;
      user_irq   <= 1'b0;
    end else begin
      core_start <= start_fire;
      user_irq   <= done_hit & ~done_q & irq_en_q;
    end
  end

  // CTRL.IRQ_EN and the sticky STATUS flags; a new set beats a W1C clear
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= user_wr_data[2];

      if (soft_rst_cmd)                     done_q <= 1'b0;
      else if (done_hit)                    done_q <= 1'b1;
      else if (wr_status && user_wr_data[1]) done_q <= 1'b0;

      if (soft_rst_cmd)                     ovf_q <= 1'b0;
      else if (ovf_set)                     ovf_q <= 1'b1;
      else if (wr_status && user_wr_data[4]) ovf_q <= 1'b0;
    end
  end

  // Configuration registers with per-byte write enables
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      core_win_cfg <= 32'h0;
      core_thresh  <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (wr_win && user_wstrb[b])    core_win_cfg[8*b +: 8] <= user_wr_data[8*b +: 8];
        if (wr_thresh && user_wstrb[b]) core_thresh[8*b +: 8]  <= user_wr_data[8*b +: 8];
      end
    end
  end

  // Result FIFO status and transfer qualifiers
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  assign res_ready  = ~fifo_full;
  assign pop        = rd_result & ~fifo_empty;
  assign push       = res_valid & (~fifo_full | pop);
  assign ovf_set    = res_valid & ~push;
  assign count_ext  = 32'(fifo_count);

  // FIFO storage; contents need no reset since pointers gate every read
  always_ff @(posedge user_clk) begin
    if (push) fifo_mem[wr_ptr] <= res_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (soft_rst_cmd) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef HOG_LITE_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;

  // RUN-cycle counter: cleared on entry to RUN, frozen once back in IDLE
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      cycle_cnt <= 32'h0;
    end else if (soft_rst_cmd || start_fire) begin
      cycle_cnt <= 32'h0;
    end else if (state_q == S_RUN && cycle_cnt != 32'hFFFF_FFFF) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

  // Read data selection for the addressed register
  always_comb begin
    rd_mux = 32'h0;
    case (reg_idx)
      A_CTRL:   rd_mux = {29'h0, irq_en_q, 2'b00};
      A_STATUS: rd_mux = {16'h0, count_ext[7:0], 3'b000, ovf_q, fifo_full,
                          fifo_empty, done_q, (state_q == S_RUN)};
      A_WIN:    rd_mux = core_win_cfg;
      A_THRESH: rd_mux = core_thresh;
      A_RESULT: rd_mux = fifo_empty ? 32'h0 : fifo_mem[rd_ptr];
      A_ID:     rd_mux = ID_VALUE;
`ifdef HOG_LITE_CYCLE_CNT_EN
      A_CYCLES: rd_mux = cycle_cnt;
`else
      A_CYCLES: rd_mux = 32'h0;
`endif
      default:  rd_mux = 32'h0;
    endcase
  end

  // Registered read data, held between reads
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst)       user_rd_data <= 32'h0;
    else if (user_rden) user_rd_data <= rd_mux;
  end

endmodule
